// File: rtl/enemy_fire_sched_pkg.sv
// enemy_fire_sched shared types and screen geometry.
// Optional x-tracking build switch for this block: AIM_TRACK_EN.
package enemy_fire_sched_pkg;

  localparam int COORD_W     = 10;
  localparam int SCREEN_W_PX = 640;
  localparam int SCREEN_H_PX = 480;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/enemy_fire_sched_if.sv
// Requester-side fire bus: level requests, spawn coords, grant pulse.
// Packed coords: requester i uses [10i+9:10i].
interface enemy_fire_sched_if #(
  parameter int N_REQ = 4
);
  import enemy_fire_sched_pkg::*;

  logic [N_REQ-1:0]         fire_req;
  logic [COORD_W*N_REQ-1:0] fire_x;
  logic [COORD_W*N_REQ-1:0] fire_y;
  logic [N_REQ-1:0]         fire_gnt;

  modport master (
    output fire_req, fire_x, fire_y,
    input  fire_gnt
  );

  modport slave (
    input  fire_req, fire_x, fire_y,
    output fire_gnt
  );

endinterface

// File: rtl/enemy_fire_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// Scan wraps modulo N; nothing is granted while en is low.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;
  int            j;

  // walk the N candidates starting at ptr, keep the first requester
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j    = (int'(ptr) + k) % N;
      cand = IW'(j);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/enemy_fire_sched.sv
// Enemy projectile pool: round-robin fire grants with global cooldown.
// Define AIM_TRACK_EN to steer live shots toward player_x on each step.
module enemy_fire_sched
  import enemy_fire_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int N_SLOT   = 4,
  parameter int COOLDOWN = 64,
  parameter int SCREEN_H = SCREEN_H_PX
) (
  input  logic                      clk_4,
  input  logic                      clr,
  input  logic                      play,
  input  logic                      step,
  enemy_fire_sched_if.slave         fire,
  input  logic [COORD_W-1:0]        player_x,
  input  logic [N_SLOT-1:0]         destroy,
  output logic [N_SLOT-1:0]         slot_active,
  output logic [COORD_W*N_SLOT-1:0] slot_x,
  output logic [COORD_W*N_SLOT-1:0] slot_y,
  output logic                      pool_full,
  output logic [7:0]                shots_fired
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam coord_t          Y_LAST   = coord_t'(SCREEN_H - 1);
  localparam logic [IW-1:0]   PTR_LAST = IW'(N_REQ - 1);
  localparam logic [CW-1:0]   CD_LOAD  = CW'(COOLDOWN - 1);

  coord_t            fx [N_REQ];
  coord_t            fy [N_REQ];
  logic [N_SLOT-1:0] act_q, act_d;
  coord_t            x_q [N_SLOT];
  coord_t            x_d [N_SLOT];
  coord_t            y_q [N_SLOT];
  coord_t            y_d [N_SLOT];
  logic [IW-1:0]     ptr_q, ptr_d, w_idx;
  logic [CW-1:0]     cd_q, cd_d;
  logic [7:0]        shots_q, shots_d;
  logic [N_REQ-1:0]  gnt_q, gnt_w;
  logic              pool_q;
  logic              grant_ok;
  logic              free_found;
  logic [SW-1:0]     free_idx;
  logic              unused_px;

  assign unused_px = ^player_x;

  assign grant_ok = play && (cd_q == '0) &&
                    (|fire.fire_req) && !(&act_q);

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req (fire.fire_req),
    .ptr (ptr_q),
    .en  (grant_ok),
    .gnt (gnt_w),
    .idx (w_idx)
  );

  // split the packed spawn buses into per-requester coords
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      fx[i] = fire.fire_x[i*COORD_W +: COORD_W];
      fy[i] = fire.fire_y[i*COORD_W +: COORD_W];
    end
  end

  // lowest-index free slot, from pre-edge occupancy only
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int j = 0; j < N_SLOT; j++) begin
      if (!free_found && !act_q[j]) begin
        free_found = 1'b1;
        free_idx   = SW'(j);
      end
    end
  end

  // next state: load on grant, else destroy beats step
  always_comb begin
    act_d   = act_q;
    x_d     = x_q;
    y_d     = y_q;
    ptr_d   = ptr_q;
    cd_d    = (cd_q != '0) ? cd_q - 1'b1 : '0;
    shots_d = shots_q;
    if (grant_ok) begin
      ptr_d   = (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;
      cd_d    = CD_LOAD;
      shots_d = shots_q + 8'd1;
    end
    for (int j = 0; j < N_SLOT; j++) begin
      if (grant_ok && free_idx == SW'(j)) begin
        act_d[j] = 1'b1;
        x_d[j]   = fx[w_idx];
        y_d[j]   = fy[w_idx];
      end else if (act_q[j] && destroy[j]) begin
        act_d[j] = 1'b0;
        x_d[j]   = '0;
        y_d[j]   = '0;
      end else if (act_q[j] && step) begin
        if (y_q[j] >= Y_LAST) begin
          act_d[j] = 1'b0;
          x_d[j]   = '0;
          y_d[j]   = '0;
        end else begin
          y_d[j] = y_q[j] + 1'b1;
`ifdef AIM_TRACK_EN
          if (player_x > x_q[j])
            x_d[j] = x_q[j] + 1'b1;
          else if (player_x < x_q[j])
            x_d[j] = x_q[j] - 1'b1;
`endif
        end
      end
    end
    if (!play) begin
      act_d   = '0;
      ptr_d   = '0;
      cd_d    = '0;
      shots_d = '0;
      for (int j = 0; j < N_SLOT; j++) begin
        x_d[j] = '0;
        y_d[j] = '0;
      end
    end
  end

  // state registers; play=0 clears through the _d path
  always_ff @(posedge clk_4 or negedge clr) begin
    if (!clr) begin
      act_q   <= '0;
      ptr_q   <= '0;
      cd_q    <= '0;
      shots_q <= '0;
      gnt_q   <= '0;
      pool_q  <= 1'b0;
      for (int j = 0; j < N_SLOT; j++) begin
        x_q[j] <= '0;
        y_q[j] <= '0;
      end
    end else begin
      act_q   <= act_d;
      ptr_q   <= ptr_d;
      cd_q    <= cd_d;
      shots_q <= shots_d;
      gnt_q   <= gnt_w;
      pool_q  <= &act_d;
      for (int j = 0; j < N_SLOT; j++) begin
        x_q[j] <= x_d[j];
        y_q[j] <= y_d[j];
      end
    end
  end

  // repack slot coordinates onto the output buses
  always_comb begin
    slot_x = '0;
    slot_y = '0;
    for (int j = 0; j < N_SLOT; j++) begin
      slot_x[j*COORD_W +: COORD_W] = x_q[j];
      slot_y[j*COORD_W +: COORD_W] = y_q[j];
    end
  end

  assign fire.fire_gnt = gnt_q;
  assign slot_active   = act_q;
  assign pool_full     = pool_q;
  assign shots_fired   = shots_q;

endmodule

// File: tb/tb_enemy_fire_sched.sv
// Bench for enemy_fire_sched: default instance plus a COOLDOWN=1 one.
// Expected x under tracking follows AIM_TRACK_EN.
module tb_enemy_fire_sched;

  typedef struct {
    int r;
    int x;
    int y;
    int n;
    int px;
    int act;
    int ex;
    int ey;
  } vec_t;

  logic        clk;
  logic        clr;
  logic        play0, step0, play1, step1;
  logic [9:0]  px0, px1;
  logic [3:0]  des0, des1;
  logic [3:0]  act0, act1;
  logic [39:0] sx0, sy0, sx1, sy1;
  logic        pf0, pf1;
  logic [7:0]  shots0, shots1;

  int          total;
  int          bad;
  int          n;
  logic [3:0]  exp_q [$];
  vec_t        tv [6];

  enemy_fire_sched_if #(.N_REQ(4)) f0 ();
  enemy_fire_sched_if #(.N_REQ(4)) f1 ();

  enemy_fire_sched #(.COOLDOWN(64)) u_dut0 (
    .clk_4       (clk),
    .clr         (clr),
    .play        (play0),
    .step        (step0),
    .fire        (f0),
    .player_x    (px0),
    .destroy     (des0),
    .slot_active (act0),
    .slot_x      (sx0),
    .slot_y      (sy0),
    .pool_full   (pf0),
    .shots_fired (shots0)
  );

  enemy_fire_sched #(.COOLDOWN(1)) u_dut1 (
    .clk_4       (clk),
    .clr         (clr),
    .play        (play1),
    .step        (step1),
    .fire        (f1),
    .player_x    (px1),
    .destroy     (des1),
    .slot_active (act1),
    .slot_x      (sx1),
    .slot_y      (sy1),
    .pool_full   (pf1),
    .shots_fired (shots1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sl(input logic [39:0] v, input int i);
    return int'(v[10*i +: 10]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (f1.fire_gnt != 4'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %b expected none", f1.fire_gnt);
      end else begin
        chk("sb_gnt", int'(f1.fire_gnt), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    tv[0] = '{0, 220, 30,  0, 220, 1, 220, 30};
    tv[1] = '{1, 100, 30,  5, 300, 1, 100, 35};
    tv[2] = '{2, 50,  478, 1, 50,  1, 50,  479};
    tv[3] = '{3, 50,  478, 2, 50,  0, 0,   0};
    tv[4] = '{0, 639, 479, 1, 0,   0, 0,   0};
    tv[5] = '{3, 300, 0,   3, 290, 1, 300, 3};
`ifdef AIM_TRACK_EN
    tv[1].ex = 105;
    tv[5].ex = 297;
`endif

    clr   = 1'b0;
    play0 = 1'b0;
    play1 = 1'b0;
    step0 = 1'b0;
    step1 = 1'b0;
    px0   = '0;
    px1   = '0;
    des0  = '0;
    des1  = '0;
    f0.fire_req = '0;
    f0.fire_x   = '0;
    f0.fire_y   = '0;
    f1.fire_req = '0;
    f1.fire_x   = '0;
    f1.fire_y   = '0;
    #12;
    chk("rst_act0", int'(act0), 0);
    chk("rst_gnt0", int'(f0.fire_gnt), 0);
    chk("rst_pool0", int'(pf0), 0);
    chk("rst_shots0", int'(shots0), 0);
    chk("rst_xy0", int'(|{sx0, sy0}), 0);
    chk("rst_act1", int'(act1), 0);

    clr   = 1'b1;
    play0 = 1'b1;
    play1 = 1'b1;
    tick();
    tick();

    f0.fire_x[9:0] = 10'd220;
    f0.fire_y[9:0] = 10'd30;
    f0.fire_req    = 4'b0001;
    tick();
    chk("t1_gnt", int'(f0.fire_gnt), 1);
    chk("t1_act", int'(act0), 1);
    chk("t1_x", sl(sx0, 0), 220);
    chk("t1_y", sl(sy0, 0), 30);
    chk("t1_shots", int'(shots0), 1);
    n = 0;
    repeat (63) begin
      tick();
      if (f0.fire_gnt != 4'b0) n++;
    end
    chk("t1_cooldown_block", n, 0);
    tick();
    chk("t1_regrant", int'(f0.fire_gnt), 1);
    chk("t1_act2", int'(act0), 3);
    chk("t1_x1", sl(sx0, 1), 220);
    chk("t1_shots2", int'(shots0), 2);
    f0.fire_req = '0;

    step0 = 1'b1;
    tick();
    step0 = 1'b0;
    chk("t6_step_y0", sl(sy0, 0), 31);
    chk("t6_step_y1", sl(sy0, 1), 31);
    play0 = 1'b0;
    #1;
    chk("t6_play_wait", int'(act0), 3);
    tick();
    chk("t6_play_act", int'(act0), 0);
    chk("t6_play_xy", int'(|{sx0, sy0}), 0);
    chk("t6_play_shots", int'(shots0), 0);
    chk("t6_play_pool", int'(pf0), 0);
    play0 = 1'b1;
    f0.fire_req = 4'b0001;
    tick();
    f0.fire_req = '0;
    chk("t6_refire", int'(act0), 1);
    #2 clr = 1'b0;
    #1;
    chk("t6_clr_act", int'(act0), 0);
    chk("t6_clr_xy", int'(|{sx0, sy0}), 0);
    chk("t6_clr_shots", int'(shots0), 0);
    chk("t6_clr_gnt", int'(f0.fire_gnt), 0);
    clr = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      play1 = 1'b0;
      tick();
      play1 = 1'b1;
      f1.fire_x[10*tv[i].r +: 10] = 10'(tv[i].x);
      f1.fire_y[10*tv[i].r +: 10] = 10'(tv[i].y);
      px1 = 10'(tv[i].px);
      exp_q.push_back(4'(1 << tv[i].r));
      f1.fire_req = 4'(1 << tv[i].r);
      tick();
      f1.fire_req = '0;
      chk("tv_load_x", sl(sx1, 0), tv[i].x);
      chk("tv_load_y", sl(sy1, 0), tv[i].y);
      repeat (tv[i].n) begin
        step1 = 1'b1;
        tick();
        step1 = 1'b0;
        tick();
      end
      chk("tv_act", int'(act1[0]), tv[i].act);
      chk("tv_x", sl(sx1, 0), tv[i].ex);
      chk("tv_y", sl(sy1, 0), tv[i].ey);
      chk("tv_shots", int'(shots1), 1);
    end

    play1 = 1'b0;
    tick();
    play1 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      f1.fire_x[10*r +: 10] = 10'(100 + r);
      f1.fire_y[10*r +: 10] = 10'(200 + 10*r);
      exp_q.push_back(4'(1 << r));
    end
    f1.fire_req = 4'b1111;
    tick();
    chk("t2_first", int'(act1), 1);
    tick();
    tick();
    tick();
    chk("t2_full_act", int'(act1), 15);
    chk("t2_pool", int'(pf1), 1);
    chk("t2_slot3_x", sl(sx1, 3), 103);
    tick();
    tick();
    chk("t2_hold_shots", int'(shots1), 4);

    des1  = 4'b0100;
    step1 = 1'b1;
    tick();
    des1 = '0;
    chk("t4_act", int'(act1), 11);
    chk("t4_x2", sl(sx1, 2), 0);
    chk("t4_y2", sl(sy1, 2), 0);
    chk("t4_y0", sl(sy1, 0), 201);
    chk("t4_pool", int'(pf1), 0);
    exp_q.push_back(4'b0001);
    tick();
    chk("t4_reload_act", int'(act1), 15);
    chk("t4_reload_x", sl(sx1, 2), 100);
    chk("t4_reload_y", sl(sy1, 2), 200);
    chk("t4_y0b", sl(sy1, 0), 202);
    chk("t4_pool2", int'(pf1), 1);
    chk("t4_shots", int'(shots1), 5);
    step1 = 1'b0;
    f1.fire_req = '0;
    tick();
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
